// File: rtl/multi_priority_arbiter.sv
// multi_priority_arbiter: registered N-request / K-grant priority encoder with
// fixed or round-robin priority and valid/ready handshakes on both sides.
module multi_priority_arbiter #(
    parameter  int N_REQ   = 12,
    parameter  int N_GRANT = 2,
    localparam int IDX_W   = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(N_REQ + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     rr_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_GRANT*IDX_W-1:0] grant_idx,
    output logic [N_GRANT-1:0]       grant_vld,
    output logic [CNT_W-1:0]         req_count,
    output logic                     out_valid,
    input  logic                     out_ready
);
    logic [IDX_W-1:0]         ptr;
    logic [IDX_W-1:0]         ptr_nxt;
    logic [N_GRANT*IDX_W-1:0] idx_nxt;
    logic [N_GRANT-1:0]       vld_nxt;
    logic                     accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Walk every position once from the start point, wrapping past N_REQ-1,
    // filling slots in the order set bits are met.
    always_comb begin
        int start;
        int k;
        idx_nxt = '0;
        vld_nxt = '0;
        ptr_nxt = ptr;
        start   = rr_en ? int'(ptr) : 0;
        k       = 0;
        for (int j = 0; j < N_REQ; j++) begin
            int p;
            logic [IDX_W-1:0] pos;
            p   = start + j;
            p   = (p >= N_REQ) ? p - N_REQ : p;
            pos = IDX_W'(p);
            if (req[pos] && k < N_GRANT) begin
                for (int s = 0; s < N_GRANT; s++) begin
                    if (k == s) begin
                        idx_nxt[s*IDX_W +: IDX_W] = pos;
                        vld_nxt[s]                = 1'b1;
                    end
                end
                ptr_nxt = IDX_W'((p + 1 == N_REQ) ? 0 : p + 1);
                k       = k + 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            grant_idx <= '0;
            grant_vld <= '0;
            req_count <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            grant_idx <= idx_nxt;
            grant_vld <= vld_nxt;
            req_count <= CNT_W'($countones(req));
            if (rr_en) ptr <= ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multi_priority_arbiter.sv
// tb_multi_priority_arbiter: directed vectors with literal expectations, plus a
// queue-based reference model compared against the DUT on every falling edge.
module tb_multi_priority_arbiter;
    localparam int N  = 12;
    localparam int G  = 2;
    localparam int IW = 4;
    localparam int CW = 4;

    logic          clk = 0;
    logic          rst = 0;
    logic [N-1:0]  req = '0;
    logic          rr_en = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [G*IW-1:0] grant_idx;
    logic [G-1:0]  grant_vld;
    logic [CW-1:0] req_count;
    logic          out_valid;
    logic          out_ready = 1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    multi_priority_arbiter #(.N_REQ(N), .N_GRANT(G)) dut (
        .clk(clk), .rst(rst), .req(req), .rr_en(rr_en), .in_valid(in_valid),
        .in_ready(in_ready), .grant_idx(grant_idx), .grant_vld(grant_vld),
        .req_count(req_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the grant order is the list of set bits at or above ptr,
    // followed by those below it (fixed mode treats ptr as 0).
    logic            m_valid = 0;
    logic [G*IW-1:0] m_idx = '0;
    logic [G-1:0]    m_vld = '0;
    logic [CW-1:0]   m_cnt = '0;
    int              m_ptr = 0;
    int              order[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_idx <= '0; m_vld <= '0; m_cnt <= '0; m_ptr <= 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            int base;
            int ng;
            logic [G*IW-1:0] t_idx;
            logic [G-1:0]    t_vld;
            base = rr_en ? m_ptr : 0;
            order.delete();
            for (int i = base; i < N; i++) if (req[i]) order.push_back(i);
            for (int i = 0; i < base; i++) if (req[i]) order.push_back(i);
            ng = (order.size() < G) ? order.size() : G;
            t_idx = '0;
            t_vld = '0;
            for (int k = 0; k < ng; k++) begin
                t_idx[k*IW +: IW] = IW'(order[k]);
                t_vld[k] = 1'b1;
            end
            m_valid <= 1;
            m_idx   <= t_idx;
            m_vld   <= t_vld;
            m_cnt   <= CW'($countones(req));
            if (rr_en && ng > 0) m_ptr <= (order[ng-1] + 1) % N;
        end else if (out_ready) begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_grant_idx", 32'(grant_idx), 32'(m_idx));
            check("model_grant_vld", 32'(grant_vld), 32'(m_vld));
            check("model_req_count", 32'(req_count), 32'(m_cnt));
        end
    end

    task automatic expect_out(input string nm, input logic v, input int i0, input int i1,
                              input logic [G-1:0] gv, input int c);
        check({nm, "_valid"}, 32'(out_valid), 32'(v));
        check({nm, "_slot0"}, 32'(grant_idx[IW-1:0]), 32'(i0));
        check({nm, "_slot1"}, 32'(grant_idx[2*IW-1:IW]), 32'(i1));
        check({nm, "_vld"}, 32'(grant_vld), 32'(gv));
        check({nm, "_count"}, 32'(req_count), 32'(c));
    endtask

    task automatic send(input logic [N-1:0] r, input logic rr);
        req = r;
        rr_en = rr;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    initial begin
        #2 rst = 1;
        chk_en = 1;
        #18;
        expect_out("reset", 0, 0, 0, 2'b00, 0);
        rst = 0;
        @(posedge clk);
        #1;
        send(12'h208, 0);
        expect_out("t1_fixed", 1, 3, 9, 2'b11, 2);
        send(12'h001, 0);
        expect_out("t2_one", 1, 0, 0, 2'b01, 1);
        send(12'h000, 0);
        expect_out("t2_zero", 1, 0, 0, 2'b00, 0);
        send(12'h61F, 0);
        expect_out("t2_many", 1, 0, 1, 2'b11, 7);
        for (int i = 0; i < 6; i++) begin
            send(12'hFFF, 1);
            expect_out($sformatf("t3_rr%0d", i), 1, 2*i, 2*i+1, 2'b11, 12);
        end
        send(12'hFFF, 1);
        expect_out("t3_wrap", 1, 0, 1, 2'b11, 12);
        send(12'h200, 1);
        expect_out("t4_ptr10", 1, 9, 0, 2'b01, 1);
        send(12'h401, 1);
        expect_out("t4_wrap1", 1, 10, 0, 2'b11, 2);
        send(12'h401, 1);
        expect_out("t4_wrap2", 1, 10, 0, 2'b11, 2);
        send(12'h00C, 0);
        expect_out("t5_load", 1, 2, 3, 2'b11, 2);
        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            req = 12'hF00 ^ N'(i * 37);
            #1;
            check("t5_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            expect_out($sformatf("t5_hold%0d", i), 1, 2, 3, 2'b11, 2);
        end
        out_ready = 1;
        req = 12'h0A0;
        rr_en = 0;
        @(posedge clk);
        #1;
        in_valid = 0;
        expect_out("t5_reload", 1, 5, 7, 2'b11, 2);
        @(posedge clk);
        #1;
        expect_out("t5_drain", 0, 5, 7, 2'b11, 2);
        out_ready = 0;
        send(12'h020, 1);
        expect_out("t6_pre", 1, 5, 0, 2'b01, 1);
        #3 rst = 1;
        #1;
        expect_out("t6_async", 0, 0, 0, 2'b00, 0);
        #3 rst = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        send(12'hFFF, 1);
        expect_out("t6_after", 1, 0, 1, 2'b11, 12);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
